// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: eight gate functions, single-beat or accumulate mode, valid/ready on both sides.
// Optional Y_PAR parity output is enabled by defining LOGIC_GATE_UNIT_PARITY_EN.
module logic_gate_unit #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             ACC,
    input  logic             LAST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Y,
    output logic [CW-1:0]    Y_BEATS,
    output logic             TRUNC,
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    output logic             Y_PAR,
`endif
    output logic             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and a held (valid, data) pair stays stable until taken.

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2:0]       op_q, op_q_n;

    logic             accept;
    logic             emit;
    logic [WIDTH-1:0] y_n;
    logic [CW-1:0]    beats_n;
    logic             trunc_n;
    logic [WIDTH-1:0] fold;
    logic [CW-1:0]    cnt_inc;

    function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x & y);
            3'b100:  r = ~(x | y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = x;
            default: r = ~x;
        endcase
        return r;
    endfunction

    assign IN_READY  = !OUT_VALID || OUT_READY;
    assign accept    = IN_VALID && IN_READY;
    assign dbg_state = (state == ACCUM);

    // In ACCUM the latched op_q selects the fold; incoming OP and ACC are ignored.
    assign fold    = gate_fn(op_q, acc, A);
    assign cnt_inc = cnt + CW'(1);

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        op_q_n  = op_q;
        emit    = 1'b0;
        y_n     = Y;
        beats_n = Y_BEATS;
        trunc_n = TRUNC;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (!ACC) begin
                        emit    = 1'b1;
                        y_n     = gate_fn(OP, A, B);
                        beats_n = CW'(1);
                        trunc_n = 1'b0;
                    end else begin
                        op_q_n = OP;
                        acc_n  = A;
                        cnt_n  = CW'(1);
                        if (LAST) begin
                            emit    = 1'b1;
                            y_n     = A;
                            beats_n = CW'(1);
                            trunc_n = 1'b0;
                        end else begin
                            state_n = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (LAST || (cnt_inc == CW'(MAX_BEATS))) begin
                        emit    = 1'b1;
                        y_n     = fold;
                        beats_n = cnt_inc;
                        trunc_n = !LAST;
                        state_n = IDLE;
                        acc_n   = '0;
                        cnt_n   = '0;
                    end else begin
                        acc_n = fold;
                        cnt_n = cnt_inc;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            op_q  <= op_q_n;
        end
    end

    // Output register: a new result wins over a drain in the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            Y         <= '0;
            Y_BEATS   <= '0;
            TRUNC     <= 1'b0;
        end else if (emit) begin
            OUT_VALID <= 1'b1;
            Y         <= y_n;
            Y_BEATS   <= beats_n;
            TRUNC     <= trunc_n;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

`ifdef LOGIC_GATE_UNIT_PARITY_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Y_PAR <= 1'b0;
        end else if (emit) begin
            Y_PAR <= ^y_n;
        end
    end
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit with a result scoreboard; Y_PAR is checked when
// LOGIC_GATE_UNIT_PARITY_EN is defined.
module tb_logic_gate_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [2:0] OP = '0;
    logic       ACC = 1'b0;
    logic       LAST = 1'b0;
    logic       OUT_VALID;
    logic       OUT_READY = 1'b1;
    logic [7:0] Y;
    logic [4:0] Y_BEATS;
    logic       TRUNC;
    logic       dbg_state;
`ifdef LOGIC_GATE_UNIT_PARITY_EN
    logic       Y_PAR;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // {y, beats, trunc}
    logic [13:0] exp_q[$];

    logic_gate_unit #(.WIDTH(8), .MAX_BEATS(16)) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .OP(OP), .ACC(ACC), .LAST(LAST),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .Y(Y), .Y_BEATS(Y_BEATS), .TRUNC(TRUNC),
`ifdef LOGIC_GATE_UNIT_PARITY_EN
        .Y_PAR(Y_PAR),
`endif
        .dbg_state(dbg_state)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gate_ref(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        case (op)
            3'd0: return x & y;
            3'd1: return x | y;
            3'd2: return x ^ y;
            3'd3: return ~(x & y);
            3'd4: return ~(x | y);
            3'd5: return ~(x ^ y);
            3'd6: return x;
            default: return ~x;
        endcase
    endfunction

    task automatic push_exp(input logic [7:0] y, input logic [4:0] beats, input logic trunc);
        exp_q.push_back({y, beats, trunc});
    endtask

    // Driver: present a beat, wait (bounded) until accepted, return 1 time unit after the accepting edge.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic acc, input logic last);
        int waited = 0;
        A = a; B = b; OP = op; ACC = acc; LAST = last; IN_VALID = 1'b1;
        @(negedge CLK);
        while (!IN_READY && waited < 50) begin
            waited++;
            @(negedge CLK);
        end
        if (!IN_READY) chk("beat_accept_timeout", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Scoreboard: compare each result as it is consumed.
    always @(negedge CLK) begin
        if (!RST && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {18'd0, Y, Y_BEATS, TRUNC}, 32'h3FFFF);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                chk("result", {18'd0, Y, Y_BEATS, TRUNC}, {18'd0, e});
`ifdef LOGIC_GATE_UNIT_PARITY_EN
                chk("y_par", {31'd0, Y_PAR}, {31'd0, ^e[13:6]});
`endif
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        chk("rst_y", {24'd0, Y}, 32'd0);
        chk("rst_beats_trunc", {26'd0, Y_BEATS, TRUNC}, 32'd0);
`ifdef LOGIC_GATE_UNIT_PARITY_EN
        chk("rst_y_par", {31'd0, Y_PAR}, 32'd0);
`endif
        @(posedge CLK); #1;
        RST = 1'b0;

        // Single AND, one-cycle latency
        push_exp(8'h30, 5'd1, 1'b0);
        beat(8'hF0, 8'h3C, 3'b000, 1'b0, 1'b0);
        chk("and_latency_valid", {31'd0, OUT_VALID}, 32'd1);
        chk("and_latency_y", {24'd0, Y}, 32'h30);

        // Truth sweep, back-to-back
        for (int op = 0; op < 8; op++) begin
            for (int p = 0; p < 4; p++) begin
                logic [7:0] a, b;
                a = p[0] ? 8'hFF : 8'h00;
                b = p[1] ? 8'hFF : 8'h00;
                push_exp(gate_ref(op[2:0], a, b), 5'd1, 1'b0);
                beat(a, b, op[2:0], 1'b0, 1'b0);
            end
        end

        // Accumulate AND; OP change on beat 2 is ignored
        beat(8'hFF, 8'h00, 3'b000, 1'b1, 1'b0);
        chk("acc_state_open", {31'd0, dbg_state}, 32'd1);
        beat(8'h0F, 8'h00, 3'b001, 1'b1, 1'b0);
        push_exp(8'h0C, 5'd3, 1'b0);
        beat(8'h3C, 8'h00, 3'b001, 1'b1, 1'b1);
        chk("acc_state_closed", {31'd0, dbg_state}, 32'd0);

        // Backpressure
        repeat (2) @(posedge CLK);
        #1;
        OUT_READY = 1'b0;
        push_exp(8'h55, 5'd1, 1'b0);
        beat(8'hAA, 8'hFF, 3'b010, 1'b0, 1'b0);
        push_exp(8'h00, 5'd1, 1'b0);
        A = 8'h01; B = 8'h01; OP = 3'b010; ACC = 1'b0; LAST = 1'b0; IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("bp_in_ready_low", {31'd0, IN_READY}, 32'd0);
            chk("bp_y_held", {24'd0, Y}, 32'h55);
            chk("bp_valid_held", {31'd0, OUT_VALID}, 32'd1);
        end
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        chk("bp_release_y", {24'd0, Y}, 32'h00);
        chk("bp_release_valid", {31'd0, OUT_VALID}, 32'd1);

        // Truncation at MAX_BEATS
        for (int i = 0; i < 16; i++) begin
            logic [7:0] a;
            a = 8'd1 << (i % 8);
            if (i == 15) push_exp(8'hFF, 5'd16, 1'b1);
            beat(a, 8'h00, 3'b001, 1'b1, 1'b0);
        end
        chk("trunc_state_idle", {31'd0, dbg_state}, 32'd0);
        chk("trunc_flag", {31'd0, TRUNC}, 32'd1);
        beat(8'hF0, 8'h00, 3'b010, 1'b1, 1'b0);
        push_exp(8'h0F, 5'd2, 1'b0);
        beat(8'hFF, 8'h00, 3'b000, 1'b1, 1'b1);

        // Reset mid-sequence
        beat(8'h12, 8'h00, 3'b001, 1'b1, 1'b0);
        beat(8'h34, 8'h00, 3'b001, 1'b1, 1'b0);
        RST = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        chk("midrst_y", {24'd0, Y}, 32'd0);
        chk("midrst_state", {31'd0, dbg_state}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        push_exp(8'h81, 5'd1, 1'b0);
        beat(8'h81, 8'h00, 3'b000, 1'b1, 1'b1);

        repeat (5) @(negedge CLK);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
